// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared event type, constants and round-robin picker for buffered_spike_router
package router_pkg;

    localparam int EVT_ADDR_W = 6;
    localparam int MAX_COLS   = 32;
    localparam int IDX_W      = 5;

    // LUT entry value meaning "this column is not wired to this row"
    localparam logic [EVT_ADDR_W-1:0] NO_CONN = '0;

    typedef struct packed {
        logic                  on_off;
        logic [EVT_ADDR_W-1:0] addr;
    } spike_event_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of mask[n-1:0], scanning upward from ptr and wrapping at n.
    // ptr must be below n.
    function automatic rr_pick_t rr_pick(input logic [MAX_COLS-1:0] mask,
                                         input logic [IDX_W-1:0]    ptr,
                                         input int unsigned         n);
        rr_pick_t    res;
        int unsigned c;
        res = '0;
        for (int unsigned k = 0; k < MAX_COLS; k++) begin
            if (k < n) begin
                c = 32'(ptr) + k;
                if (c >= n) begin
                    c = c - n;
                end
                if (!res.found && mask[c[IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = c[IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// rtl/spike_event_fifo.sv - per-row event FIFO with extra-bit full/empty pointers
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write push_data_i (accepted when not full, or when popping in the same cycle)
//   pop_i        : drop the head entry (ignored when empty)
//   full_o       : DEPTH entries stored
//   empty_o      : no entries stored
//   head_o       : oldest entry, valid while not empty
module spike_event_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    always_comb begin
        empty_o = (wptr_q == rptr_q);
        full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_pop  = pop_i && !empty_o;
        // a pop in the same cycle frees the slot a push into a full FIFO needs
        do_push = push_i && (!full_o || do_pop);
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
        head_o  = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/buffered_spike_router.sv
// rtl/buffered_spike_router.sv - LUT-based column-to-row spike router with per-row buffering
//   clk, rst_n                      : clock, asynchronous active-low reset
//   col_valid, col_on_off           : column spikes and their on/off flags
//   lut_addr                        : [r][c] target address, 0 = unconnected
//   ext_valid, ext_on_off, ext_addr : external stimulus per row, accepted with ext_ready
//   out_valid, out_on_off, out_addr : registered per-row output, held until out_ready
//   clear_counts, drop_count        : saturating per-row lost-spike counters and their clear
module buffered_spike_router
    import router_pkg::*;
#(
    parameter int NUM_COLS   = 4,
    parameter int NUM_ROWS   = 4,
    parameter int ADDR_W     = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_COLS-1:0]                  col_valid,
    input  logic [NUM_COLS-1:0]                  col_on_off,
    input  logic [NUM_ROWS*NUM_COLS*ADDR_W-1:0]  lut_addr,
    input  logic [NUM_ROWS-1:0]                  ext_valid,
    input  logic [NUM_ROWS-1:0]                  ext_on_off,
    input  logic [NUM_ROWS*ADDR_W-1:0]           ext_addr,
    output logic [NUM_ROWS-1:0]                  ext_ready,
    output logic [NUM_ROWS-1:0]                  out_valid,
    output logic [NUM_ROWS-1:0]                  out_on_off,
    output logic [NUM_ROWS*ADDR_W-1:0]           out_addr,
    input  logic [NUM_ROWS-1:0]                  out_ready,
    input  logic                                 clear_counts,
    output logic [NUM_ROWS*CNT_W-1:0]            drop_count
);

    localparam int PTR_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int EVT_W = ADDR_W + 1;
    // wide enough to add every column's drop in one cycle before saturating
    localparam int SUM_W = CNT_W + $clog2(NUM_COLS + 1);

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        logic [NUM_COLS-1:0][ADDR_W-1:0] lut_row;
        logic [NUM_COLS-1:0]             ev, gnt;
        logic [NUM_COLS-1:0]             pend_q, pend_d, pend_oo_q, pend_oo_d;
        logic [PTR_W-1:0]                ptr_q, ptr_d, gidx;
        rr_pick_t                        pick;
        logic                            grant;
        logic [SUM_W-1:0]                drop_n, cnt_sum;
        logic [CNT_W-1:0]                cnt_q, cnt_d;
        logic                            fifo_full, fifo_empty, load, pop, take_ext;
        logic [EVT_W-1:0]                push_data, head;
        logic                            ov_q, ov_d, oo_q, oo_d;
        logic [ADDR_W-1:0]               oa_q, oa_d;

        always_comb begin
            lut_row = '0;
            ev      = '0;
            for (int c = 0; c < NUM_COLS; c++) begin
                lut_row[c] = lut_addr[(r*NUM_COLS + c)*ADDR_W +: ADDR_W];
                ev[c]      = col_valid[c] && (lut_row[c] != ADDR_W'(NO_CONN));
            end
        end

        always_comb begin
            pick      = rr_pick(MAX_COLS'(pend_q), IDX_W'(ptr_q), NUM_COLS);
            grant     = pick.found && !fifo_full;
            gidx      = PTR_W'(pick.idx);
            gnt       = grant ? (NUM_COLS'(1) << gidx) : '0;
            // the address is taken from the LUT now, only on_off was latched at capture
            push_data = {pend_oo_q[gidx], lut_row[gidx]};
            if (!grant) begin
                ptr_d = ptr_q;
            end else if (32'(gidx) == NUM_COLS - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gidx + 1'b1;
            end

            // a bit being granted this cycle is free to take a new event
            pend_d    = pend_q;
            pend_oo_d = pend_oo_q;
            drop_n    = '0;
            for (int c = 0; c < NUM_COLS; c++) begin
                pend_d[c] = ev[c] || (pend_q[c] && !gnt[c]);
                if (ev[c] && (!pend_q[c] || gnt[c])) begin
                    pend_oo_d[c] = col_on_off[c];
                end
                if (ev[c] && pend_q[c] && !gnt[c]) begin
                    drop_n = drop_n + 1'b1;
                end
            end
            cnt_sum = SUM_W'(cnt_q) + drop_n;
            if (clear_counts) begin
                cnt_d = '0;
            end else if (cnt_sum > SUM_W'({CNT_W{1'b1}})) begin
                cnt_d = '1;
            end else begin
                cnt_d = cnt_sum[CNT_W-1:0];
            end
        end

        // feedback events always win over external stimulus
        always_comb begin
            load     = !ov_q || out_ready[r];
            pop      = load && !fifo_empty;
            take_ext = load && fifo_empty && ext_valid[r];
            ov_d     = ov_q;
            oo_d     = oo_q;
            oa_d     = oa_q;
            if (pop) begin
                ov_d = 1'b1;
                oo_d = head[ADDR_W];
                oa_d = head[ADDR_W-1:0];
            end else if (take_ext) begin
                ov_d = 1'b1;
                oo_d = ext_on_off[r];
                oa_d = ext_addr[r*ADDR_W +: ADDR_W];
            end else if (load) begin
                ov_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_q    <= '0;
                pend_oo_q <= '0;
                ptr_q     <= '0;
                cnt_q     <= '0;
                ov_q      <= 1'b0;
                oo_q      <= 1'b0;
                oa_q      <= '0;
            end else begin
                pend_q    <= pend_d;
                pend_oo_q <= pend_oo_d;
                ptr_q     <= ptr_d;
                cnt_q     <= cnt_d;
                ov_q      <= ov_d;
                oo_q      <= oo_d;
                oa_q      <= oa_d;
            end
        end

        spike_event_fifo #(
            .DEPTH  (FIFO_DEPTH),
            .DATA_W (EVT_W)
        ) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .push_i      (grant),
            .push_data_i (push_data),
            .pop_i       (pop),
            .full_o      (fifo_full),
            .empty_o     (fifo_empty),
            .head_o      (head)
        );

        assign ext_ready[r]                     = rst_n && load && fifo_empty;
        assign out_valid[r]                     = ov_q;
        assign out_on_off[r]                    = oo_q;
        assign out_addr[r*ADDR_W +: ADDR_W]     = oa_q;
        assign drop_count[r*CNT_W +: CNT_W]     = cnt_q;
    end

endmodule

// File: tb/tb_buffered_spike_router.sv
// tb/tb_buffered_spike_router.sv - self-checking bench for buffered_spike_router
module tb_buffered_spike_router;
    import router_pkg::*;

    localparam int NC = 4;
    localparam int NR = 4;
    localparam int AW = 6;
    localparam int FD = 4;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NC-1:0]     col_valid, col_on_off;
    logic [NR*NC*AW-1:0] lut_addr;
    logic [NR-1:0]     ext_valid, ext_on_off, ext_ready;
    logic [NR-1:0]     out_valid, out_on_off, out_ready;
    logic [NR*AW-1:0]  ext_addr, out_addr;
    logic              clear_counts;
    logic [NR*CW-1:0]  drop_count;

    always #5 clk = ~clk;

    buffered_spike_router #(
        .NUM_COLS(NC), .NUM_ROWS(NR), .ADDR_W(AW), .FIFO_DEPTH(FD), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .col_valid(col_valid), .col_on_off(col_on_off), .lut_addr(lut_addr),
        .ext_valid(ext_valid), .ext_on_off(ext_on_off), .ext_addr(ext_addr), .ext_ready(ext_ready),
        .out_valid(out_valid), .out_on_off(out_on_off), .out_addr(out_addr), .out_ready(out_ready),
        .clear_counts(clear_counts), .drop_count(drop_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int           row;
        spike_event_t ev;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit             is_ext;
        int             row;
        int             col;
        logic [AW-1:0]  addr;
        logic           oo;
        int             lat;
    } vec_t;
    localparam int NV = 6;
    vec_t tv[NV];

    int            seen;
    logic [5:0]    hist;
    logic [NR-1:0] exp_valid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // every accepted output is matched against the oldest expectation for its row
    always @(negedge clk) begin
        for (int r = 0; r < NR; r++) begin
            if (rst_n && out_valid[r] && out_ready[r]) begin
                automatic int idx = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (idx < 0 && sb[i].row == r) idx = i;
                end
                if (idx < 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected row %0d: got addr %0h, expected no output (t=%0t)",
                             r, out_addr[r*AW +: AW], $time);
                end else begin
                    check($sformatf("sb_data_row%0d", r), {out_on_off[r], out_addr[r*AW +: AW]}, sb[idx].ev);
                    sb.delete(idx);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lut(input int r, input int c, input logic [AW-1:0] a);
        lut_addr[(r*NC + c)*AW +: AW] = a;
    endtask

    task automatic expect_ev(input int r, input logic oo, input logic [AW-1:0] a);
        exp_t e;
        e.row       = r;
        e.ev.on_off = oo;
        e.ev.addr   = a;
        sb.push_back(e);
    endtask

    function automatic int drop_of(input int r);
        return int'(drop_count[r*CW +: CW]);
    endfunction

    task automatic do_reset();
        rst_n        = 1'b0;
        col_valid    = '0;
        col_on_off   = '0;
        ext_valid    = '0;
        ext_on_off   = '0;
        ext_addr     = '0;
        lut_addr     = '0;
        clear_counts = 1'b0;
        out_ready    = '1;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain(input string name);
        out_ready = '1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        tick();
        tick();
        check(name, sb.size(), 0);
    endtask

    // five column-0 spikes into row 0 with out_ready[0] low: one in the output register, four in the FIFO
    task automatic fill_fifo();
        set_lut(0, 0, 6'd10);
        out_ready[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            col_valid[0]  = 1'b1;
            col_on_off[0] = i[0];
            expect_ev(0, i[0], 6'd10);
            tick();
        end
        col_valid[0]  = 1'b0;
        col_on_off[0] = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        tv[0] = '{0, 1, 2, 6'd5,  1'b1, 2};
        tv[1] = '{0, 0, 0, 6'd1,  1'b0, 2};
        tv[2] = '{0, 3, 3, 6'd63, 1'b1, 2};
        tv[3] = '{0, 2, 1, 6'd42, 1'b0, 2};
        tv[4] = '{1, 0, 0, 6'd9,  1'b1, 0};
        tv[5] = '{1, 3, 0, 6'd63, 1'b0, 0};

        col_valid = '0; col_on_off = '0; lut_addr = '0; clear_counts = 1'b0;
        ext_on_off = '0; ext_addr = '0; out_ready = '1;
        ext_valid = '1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_addr", out_addr, 0);
        check("reset_out_on_off", out_on_off, 0);
        check("reset_ext_ready", ext_ready, 0);
        check("reset_drop_count", drop_count, 0);
        do_reset();

        // single events, one per vector, with exact latency and idle other rows
        for (int v = 0; v < NV; v++) begin
            lut_addr = '0;
            if (!tv[v].is_ext) begin
                set_lut(tv[v].row, tv[v].col, tv[v].addr);
                col_valid[tv[v].col]  = 1'b1;
                col_on_off[tv[v].col] = tv[v].oo;
            end else begin
                ext_valid[tv[v].row]             = 1'b1;
                ext_on_off[tv[v].row]            = tv[v].oo;
                ext_addr[tv[v].row*AW +: AW]     = tv[v].addr;
                #1 check($sformatf("tv%0d_ext_ready", v), ext_ready[tv[v].row], 1);
            end
            expect_ev(tv[v].row, tv[v].oo, tv[v].addr);
            tick();
            col_valid = '0; col_on_off = '0; ext_valid = '0; ext_on_off = '0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                exp_valid = (k == tv[v].lat) ? (NR'(1) << tv[v].row) : '0;
                check($sformatf("tv%0d_valid_edge%0d", v, k), out_valid, exp_valid);
                tick();
            end
        end
        drain("tv_drain");

        // all four columns fire at once into row 0
        do_reset();
        for (int c = 0; c < NC; c++) begin
            set_lut(0, c, 6'(c + 1));
            col_on_off[c] = c[0];
            expect_ev(0, c[0], 6'(c + 1));
        end
        col_valid = '1;
        tick();
        col_valid = '0; col_on_off = '0;
        hist = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            hist[k] = out_valid[0];
            tick();
        end
        check("sim_valid_pattern", hist, 6'b111100);
        check("sim_drop", drop_of(0), 0);
        drain("sim_drain");

        // feedback beats held external stimulus; outputs stable under backpressure
        do_reset();
        set_lut(0, 1, 6'd7);
        out_ready[0]  = 1'b0;
        col_valid[1]  = 1'b1;
        col_on_off[1] = 1'b1;
        expect_ev(0, 1'b1, 6'd7);
        expect_ev(0, 1'b0, 6'd9);
        tick();
        col_valid = '0; col_on_off = '0;
        tick();
        ext_valid[0]     = 1'b1;
        ext_on_off[0]    = 1'b0;
        ext_addr[0 +: AW] = 6'd9;
        #1 check("bp_ext_ready_fifo_busy", ext_ready[0], 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid[0], 1);
            check("bp_hold_addr", out_addr[0 +: AW], 7);
            check("bp_hold_on_off", out_on_off[0], 1);
            check("bp_hold_ext_ready", ext_ready[0], 0);
            tick();
        end
        out_ready[0] = 1'b1;
        #1 check("bp_ext_ready_release", ext_ready[0], 1);
        tick();
        ext_valid = '0;
        @(negedge clk);
        check("bp_ext_addr", out_addr[0 +: AW], 9);
        tick();
        @(negedge clk);
        check("bp_idle", out_valid[0], 0);
        drain("bp_drain");

        // collision on a pending bit while the FIFO is full
        do_reset();
        fill_fifo();
        set_lut(0, 1, 6'd20);
        col_valid[1]  = 1'b1;
        col_on_off[1] = 1'b1;
        expect_ev(0, 1'b1, 6'd20);
        tick();
        col_on_off[1] = 1'b0;
        tick();
        col_valid = '0; col_on_off = '0;
        tick();
        @(negedge clk);
        check("coll_drop", drop_of(0), 1);
        check("coll_hold_addr", out_addr[0 +: AW], 10);
        drain("coll_drain");
        check("coll_drop_after", drop_of(0), 1);

        // saturation at 3 and clear beating a coincident drop
        do_reset();
        fill_fifo();
        set_lut(0, 1, 6'd21);
        col_valid[1]  = 1'b1;
        col_on_off[1] = 1'b1;
        expect_ev(0, 1'b1, 6'd21);
        repeat (6) tick();
        @(negedge clk);
        check("sat_count", drop_of(0), 3);
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        @(negedge clk);
        check("clear_wins", drop_of(0), 0);
        tick();
        col_valid = '0; col_on_off = '0;
        @(negedge clk);
        check("count_after_clear", drop_of(0), 1);
        drain("sat_drain");

        // reset with events queued
        do_reset();
        set_lut(0, 0, 6'd11);
        out_ready[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            col_valid[0] = 1'b1;
            tick();
        end
        col_valid = '0;
        tick();
        check("pre_rst_valid", out_valid[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_ext_ready", ext_ready, 0);
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = '1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid != 0) seen++;
        end
        check("rst_no_stale", seen, 0);
        tick();
        col_valid[0]  = 1'b1;
        col_on_off[0] = 1'b1;
        expect_ev(0, 1'b1, 6'd11);
        tick();
        col_valid = '0; col_on_off = '0;
        drain("post_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/buffered_spike_router.md
Name: buffered_spike_router

Overview:
- Parametrised successor to the combinational per-row spike merger.
- Routes neuron-column output spikes to synapse rows through a per-row address lookup table and merges them with external stimulus.
- Adds per-row pending capture, round-robin column arbitration, a per-row event FIFO, a valid/ready output handshake and saturating drop counters, so simultaneous column spikes are no longer silently lost.
- Sits between the neural network column outputs and the synapse-row drivers.

Parameters:
- NUM_COLS, 4, number of neuron columns.
- NUM_ROWS, 4, number of synapse rows.
- ADDR_W, 6, synapse address width; address 0 means "no connection".
- FIFO_DEPTH, 4, per-row feedback FIFO entries; power of two, at least 2.
- CNT_W, 16, drop counter width.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- col_valid  in  NUM_COLS  column c fired this cycle.
- col_on_off  in  NUM_COLS  on/off flag per column.
- lut_addr  in  NUM_ROWS*NUM_COLS*ADDR_W  entry [r][c] is the target address; 0 means unconnected. Quasi-static.
- ext_valid  in  NUM_ROWS  external stimulus valid per row.
- ext_on_off  in  NUM_ROWS  external on/off flag.
- ext_addr  in  NUM_ROWS*ADDR_W  external address.
- ext_ready  out  NUM_ROWS  external stimulus accepted when high together with ext_valid.
- out_valid  out  NUM_ROWS  registered output spike valid.
- out_on_off  out  NUM_ROWS  registered output on/off flag.
- out_addr  out  NUM_ROWS*ADDR_W  registered output address.
- out_ready  in  NUM_ROWS  downstream accepts the output.
- clear_counts  in  1  synchronous clear of all drop counters.
- drop_count  out  NUM_ROWS*CNT_W  saturating per-row count of lost feedback spikes.

Behaviour:
- Reset (asynchronous assert, synchronous deassert at the clk edge):
  - pending bits, FIFOs, round-robin pointers and drop_count are 0.
  - out_valid, out_on_off and out_addr are 0.
  - ext_ready is 0 while rst_n is low.
  - A reset in mid-operation discards all queued events.
- Capture, each row r and column c:
  - The event is raised when col_valid[c] is high and lut[r][c] is nonzero.
  - At the clk edge it sets pend[r][c] and stores pend_on_off[r][c] = col_on_off[c].
- Arbitration:
  - Round-robin over pend[r] starting at ptr[r].
  - At most one grant per row per cycle, and only if FIFO r is not full.
  - The granted event {on_off, lut[r][c]} is pushed. The address is read from the LUT at grant time.
  - pend[r][c] is cleared and ptr[r] becomes (c+1) mod NUM_COLS.
  - FIFO full: no grant; pending bits hold.
- Collision on pend[r][c]:
  - New event arrives while the bit is set and not granted this cycle: the new event is dropped, the stored one is kept, and drop_count[r] is incremented.
  - Bit set and granted in the same cycle: the new event is captured and nothing is dropped.
- Output register, per row:
  - Loads when out_valid is 0 or out_ready is 1.
  - Source priority: FIFO head first (pop), otherwise external stimulus when ext_valid is high; otherwise out_valid goes to 0.
  - ext_ready[r] = load condition AND FIFO r empty. This is combinational.
  - While out_valid is high and out_ready is low, all out signals hold stable.
- Latency (uncongested):
  - Column spike sampled at edge t: out_valid high after edge t+2. This is the fixed minimum.
  - External stimulus accepted at edge t: out_valid high after edge t.
- Drop counters:
  - Saturate at 2^CNT_W-1.
  - clear_counts zeroes all counters next edge and has priority over a simultaneous increment, which is not counted.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.
- Push and pop in the same cycle are allowed when full (pop frees the slot first) and when empty.

Decomposition:
- Package router_pkg holds:
  - typedef spike_event_t, a packed struct {on_off, addr[ADDR_W]}.
  - localparam NO_CONN = 0.
  - Function rr_pick(mask, ptr), returning the grant index and a found flag.
- Sub-module spike_event_fifo: parametrised DEPTH with push/pop/full/empty and head data. It is instantiated once per row.

Test Plan:
- Single spike: lut[1][2]=5, col_valid=0b0100, on_off=1, out_ready=1 -> out_valid[1] for 1 cycle, 3 edges later, with addr=5, on_off=1. Other rows stay idle.
- Simultaneous: lut[0][0..3]=1,2,3,4, all columns fire once, ptr=0 -> row 0 outputs addr 1,2,3,4 on consecutive cycles; drop_count[0]=0.
- Priority/backpressure: ext_valid[0] held with addr 9, feedback spike queued, out_ready=0 for 3 cycles -> outputs are held stable; feedback is emitted first, then addr 9; ext_ready[0] stays low until the FIFO is empty.
- Collision: column 1 fires 2 cycles in a row while the FIFO is full and out_ready=0 -> drop_count[0]=1. The first event is delivered once out_ready=1.
- Saturation/clear: CNT_W=2, force 5 drops -> count 3. Assert clear_counts coincident with a drop -> count 0.
- Reset mid-stream: rst_n low with 3 events queued -> out_valid is 0 immediately; after release no stale events appear.
